// File: rtl/ctrl_seq_unit.sv
// Multi-cycle control sequencer for the accumulator CPU: fetch, decode, indirect, execute, halt.
// Optional SINGLE_STEP_EN adds a step input and a STEP_WAIT state between instructions.
module ctrl_seq_unit #(
  parameter int unsigned IR_W    = 8,
  parameter int unsigned OP_W    = 3,
  parameter int unsigned BSEL_W  = 3,
  parameter int unsigned SEL_AR  = 1,
  parameter int unsigned SEL_PC  = 2,
  parameter int unsigned SEL_AC  = 4,
  parameter int unsigned SEL_IR  = 5,
  parameter int unsigned SEL_MEM = 7
) (
  input  logic              clock,
  input  logic              reset,
`ifdef SINGLE_STEP_EN
  input  logic              step,
`endif
  input  logic [IR_W-1:0]   IR,
  input  logic              mem_ready,
  output logic              load_AR,
  output logic              load_PC,
  output logic              load_DR,
  output logic              load_AC,
  output logic              load_IR,
  output logic              load_TR,
  output logic              clear_AR,
  output logic              clear_PC,
  output logic              clear_DR,
  output logic              clear_AC,
  output logic              clear_TR,
  output logic              inc_AR,
  output logic              inc_PC,
  output logic              inc_DR,
  output logic              inc_AC,
  output logic              inc_TR,
  output logic              memory_read,
  output logic              memory_write,
  output logic [BSEL_W-1:0] bus_selectors,
  output logic              alu_enable,
  output logic [OP_W-1:0]   alu_mode,
  output logic              instr_done,
  output logic              halted,
  output logic [3:0]        state_dbg
);

  // state      | meaning
  // INIT       | clear AR/PC/DR/AC/TR after reset
  // FETCH0     | AR <- PC
  // FETCH1     | read instruction, IR <- mem, PC++ on mem_ready
  // DECODE     | latch opcode/ind, AR <- IR address, dispatch
  // INDIR      | read effective address, AR <- mem on mem_ready
  // JMP        | PC <- AR
  // STORE      | write AC to memory, done on mem_ready
  // OPERAND    | read operand, DR <- mem on mem_ready
  // EXEC       | ALU operates
  // WB         | AC <- ALU result
  // HALT       | stopped until reset
  // STEP_WAIT  | wait for step pulse (SINGLE_STEP_EN only)
  typedef enum logic [3:0] {
    S_INIT      = 4'd0,
    S_FETCH0    = 4'd1,
    S_FETCH1    = 4'd2,
    S_DECODE    = 4'd3,
    S_INDIR     = 4'd4,
    S_JMP       = 4'd5,
    S_STORE     = 4'd6,
    S_OPERAND   = 4'd7,
    S_EXEC      = 4'd8,
    S_WB        = 4'd9,
    S_HALT      = 4'd10
`ifdef SINGLE_STEP_EN
    ,S_STEP_WAIT = 4'd11
`endif
  } state_t;

`ifdef SINGLE_STEP_EN
  localparam state_t S_RET = S_STEP_WAIT;
`else
  localparam state_t S_RET = S_FETCH0;
`endif

  localparam logic [2:0] OP_STORE = 3'd5;
  localparam logic [2:0] OP_JUMP  = 3'd6;
  localparam logic [2:0] OP_HALT  = 3'd7;

  state_t          state_q;
  logic [OP_W-1:0] op_q;
  logic            ind_q;

  logic [OP_W-1:0] ir_op;
  logic            ir_ind;

  assign ir_op  = IR[IR_W-2 -: OP_W];
  assign ir_ind = IR[IR_W-1];

  // ind_q is kept for debug visibility; dispatch uses the live IR bit in DECODE.
  logic unused_bits;
  assign unused_bits = ^{ind_q, IR};

  function automatic state_t dispatch(input logic [2:0] op3);
    case (op3)
      OP_JUMP:  return S_JMP;
      OP_STORE: return S_STORE;
      default:  return S_OPERAND;
    endcase
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
      op_q    <= '0;
      ind_q   <= 1'b0;
    end else begin
      case (state_q)
        S_INIT:   state_q <= S_FETCH0;
        S_FETCH0: state_q <= S_FETCH1;
        S_FETCH1: if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          op_q  <= ir_op;
          ind_q <= ir_ind;
          if (ir_op[2:0] == OP_HALT)
            state_q <= S_HALT;
          else if (ir_ind)
            state_q <= S_INDIR;
          else
            state_q <= dispatch(ir_op[2:0]);
        end
        S_INDIR:   if (mem_ready) state_q <= dispatch(op_q[2:0]);
        S_JMP:     state_q <= S_RET;
        S_STORE:   if (mem_ready) state_q <= S_RET;
        S_OPERAND: if (mem_ready) state_q <= S_EXEC;
        S_EXEC:    state_q <= S_WB;
        S_WB:      state_q <= S_RET;
        S_HALT:    state_q <= S_HALT;
`ifdef SINGLE_STEP_EN
        S_STEP_WAIT: if (step) state_q <= S_FETCH0;
`endif
        default:   state_q <= S_INIT;
      endcase
    end
  end

  assign load_TR   = 1'b0;
  assign inc_AR    = 1'b0;
  assign inc_DR    = 1'b0;
  assign inc_AC    = 1'b0;
  assign inc_TR    = 1'b0;
  assign state_dbg = state_q;

  // Decode is gated by reset so the strobes drop the moment reset asserts,
  // including the INIT clears, which only fire in the cycle after release.
  always_comb begin
    load_AR       = 1'b0;
    load_PC       = 1'b0;
    load_DR       = 1'b0;
    load_AC       = 1'b0;
    load_IR       = 1'b0;
    clear_AR      = 1'b0;
    clear_PC      = 1'b0;
    clear_DR      = 1'b0;
    clear_AC      = 1'b0;
    clear_TR      = 1'b0;
    inc_PC        = 1'b0;
    memory_read   = 1'b0;
    memory_write  = 1'b0;
    bus_selectors = BSEL_W'(SEL_MEM);
    alu_enable    = 1'b0;
    alu_mode      = '0;
    instr_done    = 1'b0;
    halted        = 1'b0;
    if (!reset) begin
      case (state_q)
        S_INIT: begin
          clear_AR = 1'b1;
          clear_PC = 1'b1;
          clear_DR = 1'b1;
          clear_AC = 1'b1;
          clear_TR = 1'b1;
        end
        S_FETCH0: begin
          bus_selectors = BSEL_W'(SEL_PC);
          load_AR       = 1'b1;
        end
        S_FETCH1: begin
          memory_read = 1'b1;
          load_IR     = mem_ready;
          inc_PC      = mem_ready;
        end
        S_DECODE: begin
          bus_selectors = BSEL_W'(SEL_IR);
          load_AR       = 1'b1;
        end
        S_INDIR: begin
          memory_read = 1'b1;
          load_AR     = mem_ready;
        end
        S_JMP: begin
          bus_selectors = BSEL_W'(SEL_AR);
          load_PC       = 1'b1;
          instr_done    = 1'b1;
        end
        S_STORE: begin
          memory_write  = 1'b1;
          bus_selectors = BSEL_W'(SEL_AC);
          instr_done    = mem_ready;
        end
        S_OPERAND: begin
          memory_read = 1'b1;
          load_DR     = mem_ready;
        end
        S_EXEC: begin
          alu_enable = 1'b1;
          alu_mode   = op_q;
        end
        S_WB: begin
          alu_enable = 1'b1;
          alu_mode   = op_q;
          load_AC    = 1'b1;
          instr_done = 1'b1;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_seq_unit.sv
// Scoreboard bench for ctrl_seq_unit: instruction-level reference model pushes
// per-cycle expected outputs; a negedge monitor pops and compares.
module tb_ctrl_seq_unit;

  localparam int SEL_AR = 1, SEL_PC = 2, SEL_AC = 4, SEL_IR = 5, SEL_MEM = 7;

  localparam logic [20:0] LAR  = 21'h1 << 20;
  localparam logic [20:0] LPC  = 21'h1 << 19;
  localparam logic [20:0] LDR  = 21'h1 << 18;
  localparam logic [20:0] LAC  = 21'h1 << 17;
  localparam logic [20:0] LIR  = 21'h1 << 16;
  localparam logic [20:0] CAR  = 21'h1 << 14;
  localparam logic [20:0] CPC  = 21'h1 << 13;
  localparam logic [20:0] CDR  = 21'h1 << 12;
  localparam logic [20:0] CAC  = 21'h1 << 11;
  localparam logic [20:0] CTR  = 21'h1 << 10;
  localparam logic [20:0] IPC  = 21'h1 << 8;
  localparam logic [20:0] MRD  = 21'h1 << 4;
  localparam logic [20:0] MWR  = 21'h1 << 3;
  localparam logic [20:0] ALU  = 21'h1 << 2;
  localparam logic [20:0] DONE = 21'h1 << 1;
  localparam logic [20:0] HLT  = 21'h1;

  logic       clock = 1'b1;
  logic       reset;
  logic [7:0] IR;
  logic       mem_ready;
  logic load_AR, load_PC, load_DR, load_AC, load_IR, load_TR;
  logic clear_AR, clear_PC, clear_DR, clear_AC, clear_TR;
  logic inc_AR, inc_PC, inc_DR, inc_AC, inc_TR;
  logic memory_read, memory_write, alu_enable, instr_done, halted;
  logic [2:0] bus_selectors;
  logic [2:0] alu_mode;
  logic [3:0] state_dbg;

  ctrl_seq_unit #(
    .IR_W(8), .OP_W(3), .BSEL_W(3), .SEL_AR(SEL_AR), .SEL_PC(SEL_PC),
    .SEL_AC(SEL_AC), .SEL_IR(SEL_IR), .SEL_MEM(SEL_MEM)
  ) dut (
    .clock(clock), .reset(reset), .IR(IR), .mem_ready(mem_ready),
    .load_AR(load_AR), .load_PC(load_PC), .load_DR(load_DR), .load_AC(load_AC),
    .load_IR(load_IR), .load_TR(load_TR),
    .clear_AR(clear_AR), .clear_PC(clear_PC), .clear_DR(clear_DR),
    .clear_AC(clear_AC), .clear_TR(clear_TR),
    .inc_AR(inc_AR), .inc_PC(inc_PC), .inc_DR(inc_DR), .inc_AC(inc_AC), .inc_TR(inc_TR),
    .memory_read(memory_read), .memory_write(memory_write),
    .bus_selectors(bus_selectors), .alu_enable(alu_enable), .alu_mode(alu_mode),
    .instr_done(instr_done), .halted(halted), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       nm;
    logic [20:0] fl;
    logic [2:0]  bus;
    logic [2:0]  mode;
    logic [3:0]  dbg;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  bit   rand_mr = 1'b0;
  logic [20:0] act_fl;

  assign act_fl = {load_AR, load_PC, load_DR, load_AC, load_IR, load_TR,
                   clear_AR, clear_PC, clear_DR, clear_AC, clear_TR,
                   inc_AR, inc_PC, inc_DR, inc_AC, inc_TR,
                   memory_read, memory_write, alu_enable, instr_done, halted};

  // Monitor: one expected entry per clock cycle, sampled mid-cycle.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (act_fl !== mon_e.fl || bus_selectors !== mon_e.bus ||
          alu_mode !== mon_e.mode || state_dbg !== mon_e.dbg) begin
        errors++;
        $display("FAIL %s @%0t: got fl=%06h bus=%0d mode=%0d st=%0d, expected fl=%06h bus=%0d mode=%0d st=%0d",
                 mon_e.nm, $time, act_fl, bus_selectors, alu_mode, state_dbg,
                 mon_e.fl, mon_e.bus, mon_e.mode, mon_e.dbg);
      end
    end
  end

  function automatic exp_t mk(input string nm, input int dbg, input logic [20:0] fl,
                              input int bus, input logic [2:0] mode);
    exp_t e;
    e.nm = nm; e.dbg = 4'(dbg); e.fl = fl; e.bus = 3'(bus); e.mode = mode;
    return e;
  endfunction

  function automatic logic idle_mr();
    return rand_mr ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  task automatic cyc(input logic mr, input exp_t e);
    mem_ready = mr;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic mem_phase(input int w, input exp_t base, input logic [20:0] on_rdy);
    exp_t e;
    for (int i = 0; i < w; i++) cyc(1'b0, base);
    e = base;
    e.fl = base.fl | on_rdy;
    cyc(1'b1, e);
  endtask

  task automatic fetch_decode(input logic [7:0] ir, input int wmin, input int wmax);
    IR = ir;
    cyc(idle_mr(), mk("FETCH0", 1, LAR, SEL_PC, 3'd0));
    mem_phase($urandom_range(wmax, wmin), mk("FETCH1", 2, MRD, SEL_MEM, 3'd0), LIR | IPC);
    cyc(idle_mr(), mk("DECODE", 3, LAR, SEL_IR, 3'd0));
  endtask

  // Reference: sequence of phases implied by the instruction's opcode and indirect bit.
  task automatic do_instr(input logic [7:0] ir, input int wmin, input int wmax);
    logic [2:0] op;
    op = ir[6:4];
    fetch_decode(ir, wmin, wmax);
    if (op == 3'd7) begin
      repeat (20) cyc(idle_mr(), mk("HALT", 10, HLT, SEL_MEM, 3'd0));
      return;
    end
    if (ir[7]) mem_phase($urandom_range(wmax, wmin), mk("INDIR", 4, MRD, SEL_MEM, 3'd0), LAR);
    case (op)
      3'd6: cyc(idle_mr(), mk("JMP", 5, LPC | DONE, SEL_AR, 3'd0));
      3'd5: mem_phase($urandom_range(wmax, wmin), mk("STORE", 6, MWR, SEL_AC, 3'd0), DONE);
      default: begin
        mem_phase($urandom_range(wmax, wmin), mk("OPERAND", 7, MRD, SEL_MEM, 3'd0), LDR);
        cyc(idle_mr(), mk("EXEC", 8, ALU, SEL_MEM, op));
        cyc(idle_mr(), mk("WB", 9, ALU | LAC | DONE, SEL_MEM, op));
      end
    endcase
  endtask

  task automatic reset_pulse(input logic mr);
    reset = 1'b1;
    cyc(mr, mk("RESET", 0, 21'h0, SEL_MEM, 3'd0));
    reset = 1'b0;
    cyc(idle_mr(), mk("INIT", 0, CAR | CPC | CDR | CAC | CTR, SEL_MEM, 3'd0));
  endtask

  initial begin
    logic [7:0] ir;
    reset = 1'b1;
    IR = 8'h00;
    mem_ready = 1'b0;
    cyc(1'b0, mk("RESET", 0, 21'h0, SEL_MEM, 3'd0));
    cyc(1'b1, mk("RESET", 0, 21'h0, SEL_MEM, 3'd0));
    reset = 1'b0;
    cyc(1'b1, mk("INIT", 0, CAR | CPC | CDR | CAC | CTR, SEL_MEM, 3'd0));

    do_instr(8'h01, 0, 0);
    do_instr(8'hD5, 0, 0);
    do_instr(8'h60, 0, 0);
    do_instr(8'h50, 0, 0);
    do_instr(8'h45, 3, 3);
    do_instr(8'hB2, 2, 2);

    rand_mr = 1'b1;
    repeat (60) begin
      ir = 8'($urandom);
      if (ir[6:4] == 3'd7) ir[4] = 1'b0;
      do_instr(ir, 0, 3);
    end

    // Abort while waiting on an operand read.
    fetch_decode(8'h02, 0, 1);
    cyc(1'b0, mk("OPERAND", 7, MRD, SEL_MEM, 3'd0));
    cyc(1'b0, mk("OPERAND", 7, MRD, SEL_MEM, 3'd0));
    reset_pulse(1'b0);
    do_instr(8'h13, 0, 2);

    do_instr(8'hF0, 0, 1);
    reset_pulse(1'b1);
    do_instr(8'h01, 0, 0);
    do_instr(8'h70, 0, 0);

    @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_seq_unit.md
Name: ctrl_seq_unit

Overview:
Parametrised multi-cycle control sequencer for the accumulator CPU. Successor to the fixed 8-bit control unit.
- Adds configurable IR/opcode widths and bus-select encodings.
- Adds a memory wait-state handshake, indirect addressing, JUMP, HALT and a post-reset register-clear cycle.
- Drives the load/clear/inc strobes, memory, bus-mux and ALU controls of the datapath.

Parameters:
IR_W, 8, instruction register width; IR[IR_W-1]=indirect bit, IR[IR_W-2 -: OP_W]=opcode
OP_W, 3, opcode width; must be >=3 and <=IR_W-1
BSEL_W, 3, bus selector width
SEL_AR, 1, bus code placing AR on bus
SEL_PC, 2, bus code for PC
SEL_AC, 4, bus code for AC
SEL_IR, 5, bus code for IR address field
SEL_MEM, 7, bus code for memory data (also idle code)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
IR  in  IR_W  current instruction register contents
mem_ready  in  1  memory completes the current read/write this cycle
load_AR, load_PC, load_DR, load_AC, load_IR, load_TR  out  1 each  register load strobes
clear_AR, clear_PC, clear_DR, clear_AC, clear_TR  out  1 each  register clear strobes
inc_AR, inc_PC, inc_DR, inc_AC, inc_TR  out  1 each  register increment strobes
memory_read  out  1  memory read request
memory_write  out  1  memory write request
bus_selectors  out  BSEL_W  bus mux select
alu_enable  out  1  ALU operate
alu_mode  out  OP_W  ALU operation (= latched opcode)
instr_done  out  1  one-cycle pulse on the final cycle of each instruction
halted  out  1  sequencer in HALT
state_dbg  out  4  current state code

Behaviour:
- Clock and reset: clock clock; reset reset, asynchronous, active-high.
- Output timing: state register is updated on posedge clock. All control outputs are Moore decodes of state plus the latched opcode/ind and mem_ready. Only the listed strobes are 1 in each state; all others are 0 and bus_selectors=SEL_MEM.
- While reset is high:
  - state=INIT, opcode latch=0, ind=0.
  - All strobes, memory_read, memory_write, alu_enable, instr_done and halted are 0.
  - alu_mode=0, bus_selectors=SEL_MEM.
- Opcodes (low 3 bits of the opcode field):
  - 0..4: ALU ops, read operand.
  - 5: STORE.
  - 6: JUMP.
  - 7: HALT.
  - Opcode bits above bit 2 are passed to alu_mode only.
- States (state_dbg code in brackets):
  - INIT [0]: clear_AR, clear_PC, clear_DR, clear_AC, clear_TR. -> FETCH0.
  - FETCH0 [1]: bus=SEL_PC, load_AR. -> FETCH1.
  - FETCH1 [2]: memory_read, bus=SEL_MEM. load_IR and inc_PC = mem_ready. Hold while mem_ready=0; -> DECODE when mem_ready=1.
  - DECODE [3]: latch opcode/ind from IR; bus=SEL_IR, load_AR. Dispatch in priority order:
    - HALT -> HALT (indirect bit ignored).
    - else ind -> INDIR.
    - else -> DISPATCH target.
  - DISPATCH target: JUMP -> JMP, STORE -> STORE, otherwise -> OPERAND.
  - INDIR [4]: memory_read, bus=SEL_MEM, load_AR = mem_ready. Hold until mem_ready; then -> DISPATCH target.
  - JMP [5]: bus=SEL_AR, load_PC, instr_done. -> FETCH0.
  - STORE [6]: memory_write, bus=SEL_AC, memory_read=0. Hold until mem_ready; on that cycle instr_done=1. -> FETCH0.
  - OPERAND [7]: memory_read, bus=SEL_MEM, load_DR = mem_ready. Hold until mem_ready. -> EXEC.
  - EXEC [8]: alu_enable, alu_mode=opcode. -> WB.
  - WB [9]: alu_enable, alu_mode=opcode, load_AC, instr_done. -> FETCH0.
  - HALT [10]: halted=1, all strobes 0. Exit only via reset.
- Handshake rules:
  - Memory requests stay asserted continuously until mem_ready.
  - A load/inc qualified by mem_ready fires exactly once per request.
  - mem_ready outside memory states is ignored.
- Boundaries:
  - Unused state codes -> INIT.
  - load_TR, inc_AR, inc_DR, inc_AC, inc_TR are constant 0.
  - Reset mid-instruction aborts immediately; no partial strobe is emitted after reset asserts.
- Latency with mem_ready tied 1 (INIT excluded):
  - ALU direct: 6 cycles.
  - ALU indirect: 7 cycles.
  - STORE direct: 4 cycles.
  - JUMP direct: 4 cycles.

Optional Feature:
Macro SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit) and state STEP_WAIT [11].
  - Every transition that would go to FETCH0 after instr_done goes to STEP_WAIT instead.
  - STEP_WAIT: all strobes 0. -> FETCH0 on a cycle with step=1, else hold.
  - Reset and HALT behaviour unchanged.
- Undefined: no step port, no STEP_WAIT; direct return to FETCH0.

Test Plan:
- Release reset, mem_ready=1, IR=8'h01 -> INIT clears all for 1 cycle, then FETCH0..WB. load_DR in OPERAND; alu_enable with alu_mode=3'b000 in EXEC/WB; instr_done only in the WB cycle (6th cycle after INIT).
- IR=8'hD5 (indirect STORE), mem_ready=1 -> DECODE, INDIR (load_AR, memory_read), STORE (memory_write=1, memory_read=0, bus=SEL_AC, instr_done), then FETCH0.
- mem_ready=0 for 3 cycles in FETCH1 -> memory_read held 4 cycles; load_IR and inc_PC high only on the 4th cycle, exactly once.
- IR=8'h60 (JUMP) -> JMP state: bus=SEL_AR, load_PC=1, instr_done=1, next state FETCH0.
- IR=8'h70 or 8'hF0 (HALT) -> halted=1 from the cycle after DECODE, held for 20 cycles with no strobes; reset pulse -> INIT, halted=0.
- Assert reset during OPERAND with mem_ready=0 -> all outputs 0 and bus_selectors=SEL_MEM asynchronously; after release the first state is INIT.
